// File: rtl/up_down_counter_param.sv
// up_down_counter_param
//   Bus-programmed bounded up/down counter used as a peripheral
//   timer/sequencer on an 8080-style ncs/nrd/nwr bus. The count runs between
//   LLR and ULR in steps of STEP. At each limit it either bounces (reverses
//   direction) or wraps to the opposite limit. After CCR limit events it
//   pulses ec and stops.
//
// Parameters
//   WIDTH : data bus, register and count width (must be >= 4)
//   CCR_W : cycle-count register / cycle counter width (must be <= WIDTH)
//
// Ports
//   clk    : system clock, rising edge
//   reset  : asynchronous active-low reset
//   din    : bidirectional data bus. Driven only during a clean read.
//   ncs    : chip select, active low. Counting also pauses while it is high.
//   nrd    : read strobe, active low
//   nwr    : write strobe, active low
//   addr   : register select
//            0 PLR, 1 ULR, 2 LLR, 3 CCR, 4 STEP, 5 MODE,
//            6 STATUS {busy,done,err,dir} (read-only), 7 COUNT (read-only)
//   start  : start/restart request, qualified by ncs=0
//   count  : current count
//   err    : configuration error flag
//   ec     : one-clock end-of-count pulse
//   dir    : current direction (0=up, 1=down)
module up_down_counter_param #(
    parameter int WIDTH = 8,
    parameter int CCR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    inout  wire  [WIDTH-1:0] din,
    input  logic             ncs,
    input  logic             nrd,
    input  logic             nwr,
    input  logic [2:0]       addr,
    input  logic             start,
    output logic [WIDTH-1:0] count,
    output logic             err,
    output logic             ec,
    output logic             dir
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE,
        S_ERROR
    } state_t;

    state_t state, state_n;

    logic [WIDTH-1:0] plr, ulr, llr, step;
    logic [CCR_W-1:0] ccr, cyc;
    logic [1:0]       mode;   // bit0: 1=wrap, bit1: initial direction (1=down)

    logic [WIDTH-1:0] count_n;
    logic [CCR_W-1:0] cyc_n;
    logic             dir_n, err_n, ec_n;

    logic             wr_en, rd_en, go, cfg_ok, reg_we, limit;
    logic [WIDTH:0]   up_sum, dn_diff;
    logic             up_ok, dn_ok;
    logic [CCR_W-1:0] cyc_inc;
    logic [WIDTH-1:0] rdata;

    // A strobe conflict (nrd and nwr both low) is neither a read nor a write.
    assign wr_en = !ncs && !nwr && nrd;
    assign rd_en = !ncs && !nrd && nwr && reset;
    assign go    = start && !ncs;

    // Only the writable registers count as a write. Status and count
    // addresses neither load nor clear an error.
    assign reg_we = wr_en && (state != S_RUN) && (addr < 3'd6);

    assign cfg_ok = (llr < ulr) && (llr <= plr) && (plr <= ulr) &&
                    (step != '0) && (ccr != '0);

    // One extra bit so neither direction can overflow. The down path is
    // compared signed so a step past zero reads as negative, not huge.
    assign up_sum  = {1'b0, count} + {1'b0, step};
    assign dn_diff = {1'b0, count} - {1'b0, step};
    assign up_ok   = up_sum < {1'b0, ulr};
    assign dn_ok   = $signed(dn_diff) > $signed({1'b0, llr});

    // In RUN the cycle counter stays below CCR, so cyc+1 cannot wrap.
    assign cyc_inc = cyc + 1'b1;

    // Next-state and datapath next values
    always_comb begin
        state_n = state;
        count_n = count;
        dir_n   = dir;
        cyc_n   = cyc;
        err_n   = err;
        ec_n    = 1'b0;
        limit   = 1'b0;

        if (go) begin
            // start wins in every state, including a restart mid-run
            if (cfg_ok) begin
                count_n = plr;
                dir_n   = mode[1];
                cyc_n   = '0;
                err_n   = 1'b0;
                state_n = S_RUN;
            end else begin
                err_n   = 1'b1;
                state_n = S_ERROR;
            end
        end else begin
            case (state)
                S_RUN: begin
                    if (!ncs) begin
                        if (!dir) begin
                            if (up_ok) count_n = up_sum[WIDTH-1:0];
                            else       limit   = 1'b1;
                        end else begin
                            if (dn_ok) count_n = dn_diff[WIDTH-1:0];
                            else       limit   = 1'b1;
                        end

                        if (limit) begin
                            cyc_n = cyc_inc;
                            if (mode[0]) begin
                                count_n = dir ? ulr : llr;
                            end else begin
                                count_n = dir ? llr : ulr;
                                dir_n   = !dir;
                            end
                            if (cyc_inc == ccr) begin
                                ec_n    = 1'b1;
                                state_n = S_DONE;
                            end
                        end
                    end
                end
                S_ERROR: begin
                    if (wr_en && (addr < 3'd6)) begin
                        err_n   = 1'b0;
                        state_n = S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    // Datapath and register file
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            dir   <= 1'b0;
            err   <= 1'b0;
            ec    <= 1'b0;
            cyc   <= '0;
            plr   <= '0;
            ulr   <= '1;
            llr   <= '0;
            ccr   <= CCR_W'(1);
            step  <= WIDTH'(1);
            mode  <= '0;
        end else begin
            count <= count_n;
            dir   <= dir_n;
            err   <= err_n;
            ec    <= ec_n;
            cyc   <= cyc_n;
            if (reg_we) begin
                case (addr)
                    3'd0:    plr  <= din;
                    3'd1:    ulr  <= din;
                    3'd2:    llr  <= din;
                    3'd3:    ccr  <= din[CCR_W-1:0];
                    3'd4:    step <= din;
                    3'd5:    mode <= din[1:0];
                    default: ;
                endcase
            end
        end
    end

    // Read-back mux
    always_comb begin
        rdata = '0;
        case (addr)
            3'd0:    rdata = plr;
            3'd1:    rdata = ulr;
            3'd2:    rdata = llr;
            3'd3:    rdata = WIDTH'(ccr);
            3'd4:    rdata = step;
            3'd5:    rdata = WIDTH'(mode);
            3'd6:    rdata = WIDTH'({(state == S_RUN), (state == S_DONE), err, dir});
            default: rdata = count;
        endcase
    end

    assign din = rd_en ? rdata : {WIDTH{1'bz}};

endmodule

// File: tb/tb_up_down_counter_param.sv
// tb_up_down_counter_param
//   Self-checking bench for up_down_counter_param (WIDTH=8, CCR_W=8).
//   Counting runs are described as tables of {start, ncs, expected outputs}.
//   Each row's expectation is queued when its inputs are driven and checked
//   after the following rising edge. Bus reads, pause/restart and reset are
//   hand-written sequences. The data bus is a tri1 net, so an undriven bus
//   reads back as all ones.
module tb_up_down_counter_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       ncs, nrd, nwr, start;
    logic [2:0] addr;
    logic [7:0] count;
    logic       err, ec, dir;
    logic [7:0] din_drv;
    logic       din_oe;
    tri1  [7:0] din;

    assign din = din_oe ? din_drv : 8'hzz;

    always #10 clk = ~clk;

    up_down_counter_param #(.WIDTH(8), .CCR_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .ncs   (ncs),
        .nrd   (nrd),
        .nwr   (nwr),
        .addr  (addr),
        .start (start),
        .count (count),
        .err   (err),
        .ec    (ec),
        .dir   (dir)
    );

    typedef struct {
        logic       start;
        logic       ncs;
        logic [7:0] cnt;
        logic       err;
        logic       ec;
        logic       dir;
    } vec_t;

    vec_t        tbl[$];
    logic [10:0] exp_q[$];
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic add(input logic s, input logic n, input logic [7:0] c,
                       input logic e, input logic ecv, input logic d);
        vec_t v;
        v.start = s; v.ncs = n; v.cnt = c; v.err = e; v.ec = ecv; v.dir = d;
        tbl.push_back(v);
    endtask

    // Applies each row for one clock. The queued expectation is checked
    // against {count,err,ec,dir} just after the edge.
    task automatic run_tbl(input string name);
        logic [10:0] e;
        foreach (tbl[i]) begin
            @(negedge clk);
            start = tbl[i].start;
            ncs   = tbl[i].ncs;
            exp_q.push_back({tbl[i].cnt, tbl[i].err, tbl[i].ec, tbl[i].dir});
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL %s[%0d]: scoreboard empty", name, i);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("%s[%0d] {count,err,ec,dir}", name, i),
                    {5'd0, count, err, ec, dir}, {5'd0, e});
            end
            start = 1'b0;
            ncs   = 1'b0;
        end
        tbl.delete();
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        start   = 1'b0;
        ncs     = 1'b0;
        addr    = a;
        din_drv = d;
        din_oe  = 1'b1;
        nrd     = 1'b1;
        nwr     = 1'b0;
        @(posedge clk);
        #1;
        nwr    = 1'b1;
        din_oe = 1'b0;
    endtask

    // No edge wait: the caller places it inside a low clock phase.
    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        addr = a;
        nrd  = 1'b0;
        #1;
        d    = din;
        nrd  = 1'b1;
        #1;
    endtask

    task automatic rd_chk(input string nm, input logic [2:0] a, input logic [7:0] expv);
        logic [7:0] d;
        bus_read(a, d);
        chk(nm, {8'd0, d}, {8'd0, expv});
    endtask

    task automatic cfg(input logic [7:0] p, input logic [7:0] u, input logic [7:0] l,
                       input logic [7:0] c, input logic [7:0] s, input logic [7:0] m);
        bus_write(3'd1, u);
        bus_write(3'd2, l);
        bus_write(3'd0, p);
        bus_write(3'd3, c);
        bus_write(3'd4, s);
        bus_write(3'd5, m);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; ncs = 1'b1; nrd = 1'b1; nwr = 1'b1; start = 1'b0;
        addr = 3'd0; din_drv = 8'h00; din_oe = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", {5'd0, count, err, ec, dir}, 16'd0);
        chk("reset bus idle", {8'd0, din}, 16'h00ff);
        @(negedge clk);
        reset = 1'b1;
        ncs   = 1'b0;
        rd_chk("reset ULR", 3'd1, 8'hff);
        rd_chk("reset CCR", 3'd3, 8'h01);
        rd_chk("reset STEP", 3'd4, 8'h01);
        rd_chk("reset STATUS", 3'd6, 8'h00);

        // Basic bounce: 10 up to 15, back down to 5, two limit events
        cfg(8'd10, 8'd15, 8'd5, 8'd2, 8'd1, 8'd0);
        add(1, 0, 8'd10, 0, 0, 0);
        for (int k = 1; k <= 5; k++)  add(0, 0, 8'(10 + k), 0, 0, k == 5);
        for (int k = 6; k <= 15; k++) add(0, 0, 8'(20 - k), 0, k == 15, k != 15);
        add(0, 0, 8'd5, 0, 0, 0);
        add(0, 0, 8'd5, 0, 0, 0);
        run_tbl("bounce");
        @(negedge clk);
        rd_chk("bounce STATUS done", 3'd6, 8'h04);

        // Configuration errors
        bus_write(3'd0, 8'd20);
        bus_write(3'd1, 8'd10);
        bus_write(3'd2, 8'd5);
        add(1, 0, 8'd5, 1, 0, 0);
        run_tbl("cfgerr_plr");
        @(negedge clk);
        rd_chk("cfgerr STATUS", 3'd6, 8'h02);
        bus_write(3'd0, 8'd5);
        chk("write clears err", {15'd0, err}, 16'd0);
        bus_write(3'd1, 8'd5);
        add(1, 0, 8'd5, 1, 0, 0);
        run_tbl("cfgerr_equal");
        bus_write(3'd2, 8'd0);
        chk("write clears err 2", {15'd0, err}, 16'd0);

        // Wrap with step 2, single cycle
        cfg(8'd5, 8'd8, 8'd5, 8'd1, 8'd2, 8'd1);
        add(1, 0, 8'd5, 0, 0, 0);
        add(0, 0, 8'd7, 0, 0, 0);
        add(0, 0, 8'd5, 0, 1, 0);
        add(0, 0, 8'd5, 0, 0, 0);
        run_tbl("wrap");

        // Pause at 12, then restart at 13 after one limit event. The first
        // limit after the restart must not end the run (cycles cleared).
        cfg(8'd10, 8'd15, 8'd5, 8'd2, 8'd1, 8'd0);
        add(1, 0, 8'd10, 0, 0, 0);
        add(0, 0, 8'd11, 0, 0, 0);
        add(0, 0, 8'd12, 0, 0, 0);
        add(0, 1, 8'd12, 0, 0, 0);
        add(0, 1, 8'd12, 0, 0, 0);
        add(0, 1, 8'd12, 0, 0, 0);
        add(0, 0, 8'd13, 0, 0, 0);
        add(0, 0, 8'd14, 0, 0, 0);
        add(0, 0, 8'd15, 0, 0, 1);
        add(0, 0, 8'd14, 0, 0, 1);
        add(0, 0, 8'd13, 0, 0, 1);
        add(1, 0, 8'd10, 0, 0, 0);
        for (int k = 1; k <= 5; k++)  add(0, 0, 8'(10 + k), 0, 0, k == 5);
        for (int k = 6; k <= 15; k++) add(0, 0, 8'(20 - k), 0, k == 15, k != 15);
        add(0, 0, 8'd5, 0, 0, 0);
        run_tbl("pause_restart");

        // Bus behaviour during RUN
        add(1, 0, 8'd10, 0, 0, 0);
        run_tbl("busrun_start");
        bus_write(3'd1, 8'd30);            // ignored; count steps to 11
        @(negedge clk);
        rd_chk("RUN write ignored ULR", 3'd1, 8'd15);
        rd_chk("RUN read COUNT", 3'd7, 8'd11);
        rd_chk("RUN STATUS busy", 3'd6, 8'h08);
        addr = 3'd0;
        nrd  = 1'b0;
        nwr  = 1'b0;
        #1;
        chk("conflict bus undriven", {8'd0, din}, 16'h00ff);
        din_drv = 8'h33;
        din_oe  = 1'b1;
        @(posedge clk);                    // count steps to 12
        #1;
        din_oe = 1'b0;
        nrd    = 1'b1;
        nwr    = 1'b1;
        @(negedge clk);
        rd_chk("conflict no write PLR", 3'd0, 8'd10);
        rd_chk("RUN read COUNT 2", 3'd7, 8'd12);

        // Asynchronous reset between edges, mid-run
        #2;
        reset = 1'b0;
        #1;
        chk("async reset outputs", {5'd0, count, err, ec, dir}, 16'd0);
        chk("async reset bus idle", {8'd0, din}, 16'h00ff);
        @(posedge clk);
        #1;
        chk("reset held count", {8'd0, count}, 16'd0);
        @(negedge clk);
        reset = 1'b1;
        rd_chk("post-reset ULR", 3'd1, 8'hff);
        rd_chk("post-reset PLR", 3'd0, 8'h00);
        rd_chk("post-reset STATUS", 3'd6, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/up_down_counter_param.md
Name: up_down_counter_param

Overview:
Parametrised successor to the 255-limit up/down counter. It has a WIDTH-bit bus-programmed bounded counter with a programmable step size, bounce or wrap mode, and a programmable initial direction. The full register file can be read back over the same tristate data bus. It sits on the shared 8080-style ncs/nrd/nwr bus as a peripheral timer/sequencer.

Parameters:
WIDTH, 8, width of data bus, all registers and count
CCR_W, 8, width of cycle-count register and internal cycle counter

Ports:
clk  input  1  system clock, all state changes on rising edge
reset  input  1  asynchronous active-low reset
din  inout  WIDTH  bidirectional data bus
ncs  input  1  chip select, active low
nrd  input  1  read strobe, active low
nwr  input  1  write strobe, active low
addr  input  3  register select
start  input  1  start/restart request, sampled on clk
count  output  WIDTH  current count value
err  output  1  configuration error flag, level
ec  output  1  end-of-count pulse
dir  output  1  current direction, 0=up, 1=down

Behaviour:
- Reset (reset=0, asynchronous): PLR=0, ULR=all ones, LLR=0, CCR=1, STEP=1, MODE=0; count=0, err=0, ec=0, dir=0; state IDLE; din=Z.
- Register map: 0 PLR, 1 ULR, 2 LLR, 3 CCR (CCR_W bits, zero-extended on read), 4 STEP, 5 MODE, 6 STATUS (read-only, {busy,done,err,dir} in bits 3:0), 7 COUNT (read-only).
- MODE bits: bit0 0=bounce, 1=wrap. bit1 initial direction, 1=down.
- Write: ncs=0, nwr=0, nrd=1 at a rising edge loads din into reg[addr].
  - Ignored in RUN.
  - Writes to 6 and 7 are ignored.
  - A write in ERROR clears err and returns to IDLE.
- Read: while ncs=0, nrd=0, nwr=1, din is combinationally driven with reg[addr]. Otherwise din=Z.
- Bus conflict: nrd=0 and nwr=0 together means no write and no drive.
- States: IDLE, RUN, DONE, ERROR.
- Start: start=1 with ncs=0 at a rising edge, in any state including RUN (restart), validates the configuration.
  - Validity requires LLR<ULR, LLR<=PLR<=ULR, STEP!=0 and CCR!=0.
  - Invalid: go to ERROR, err=1, count unchanged.
  - Valid: count<=PLR, dir<=MODE[1], cycle counter<=0, err<=0, go to RUN. count=PLR is visible after that same edge.
- RUN, each edge with ncs=0. Next value is computed in WIDTH+1 bits (no overflow).
  - Up, count+STEP<ULR: count+=STEP.
  - Down, count-STEP>LLR: count-=STEP. Down-step arithmetic is signed so there is no underflow.
  - Limit event: next value is beyond or equal to a limit.
    - Bounce: count<=the limit reached, dir toggles.
    - Wrap, up: count<=LLR, dir unchanged.
    - Wrap, down: count<=ULR, dir unchanged.
    - Every limit event increments the cycle counter.
- On the limit event that makes cycle counter==CCR: ec=1 for exactly one clock, registered at the same edge as the final count. Then go to DONE, count and dir held.
- ncs=1 during RUN pauses counting: count, dir and cycles held. Counting resumes when ncs returns to 0.
- DONE and ERROR hold outputs until the next start or reset. start in IDLE/DONE behaves as in RUN.
- STATUS: busy=RUN, done=DONE.

Test Plan:
- Basic bounce (WIDTH=8):
  - Stimulus: write PLR=10, ULR=15, LLR=5, CCR=2, STEP=1, MODE=0; start at edge N.
  - Response: count=10 at N, 15 at N+5 with dir=1, 5 at N+15 with ec=1 for one clock; DONE, count holds 5, err=0.
- Configuration errors:
  - PLR=20, ULR=10, LLR=5 then start: err=1 one edge after start, count unchanged, STATUS=0x2|dir.
  - PLR=ULR=LLR=5: err=1.
  - A subsequent valid write clears err.
- Wrap with step:
  - Stimulus: PLR=5, ULR=8, LLR=5, STEP=2, MODE=1, CCR=1.
  - Response: count 5, 7, then 5 at N+2 with ec=1; dir stays 0.
- Pause and mid-run start:
  - ncs=1 for 3 cycles at count=12: count held at 12, then continues 13.
  - start at count=13: count reloads PLR=10 the same edge, cycles cleared.
- Bus behaviour during RUN:
  - Write ULR=30 in RUN: ignored; reading addr 1 returns 15.
  - Read addr 7: din equals count.
  - nrd=nwr=0: din=Z, no register change.
- Asynchronous reset: assert reset=0 mid-run, between edges. All outputs go to reset values immediately, din=Z, registers return to defaults (ULR reads 255).
